// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage between the branch predictor and the IF/ID latch.
//   It holds the architectural fetch PC and presents it to the predictor. It
//   issues one 32-bit fetch at a time to the memory controller and steers the
//   next PC from the prediction or from an EX-stage redirect. Fetched
//   instructions go to decode through a one-entry output register. A single
//   skid buffer absorbs one extra instruction while decode stalls.
//
// Parameters
//   RESET_PC      PC loaded on reset
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   pc_o          current fetch PC (register output, drives predictor addr_i)
//   br_p, addr_p  predictor taken flag / target for pc_o
//   mem_req       fetch request (FETCH, KILL)
//   mem_addr      fetch address
//   mem_done      one-cycle completion pulse, mem_data valid
//   mem_data      fetched word
//   stall_i       decode cannot accept this cycle
//   flush_i       EX redirect
//   flush_addr    redirect target
//   if_valid      output register holds an instruction
//   if_pc         PC of held instruction
//   if_inst       held instruction
//   if_pred_taken prediction used for this instruction
//   if_pred_addr  predicted target, 0 when not taken
//
// States
//   IDLE  | one cycle after reset, no request
//   FETCH | request for pc_o outstanding
//   KILL  | request abandoned by a flush, waiting for its mem_done
//   FULL  | output and buffer both occupied, no request
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  input  logic        br_p,
  input  logic [31:0] addr_p,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_addr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;

  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_if_taken;
  logic [31:0] r_if_paddr;

  // Skid buffer; its contents are meaningful only while in FULL.
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_inst;
  logic        r_buf_taken;
  logic [31:0] r_buf_paddr;

  logic [31:0] w_npc;
  logic [31:0] w_pred_addr;
  logic [31:0] w_pc_nxt;
  logic        w_consumed;
  logic        w_free;
  logic        w_load_fetch;
  logic        w_load_buf;
  logic        w_fill_buf;

  assign w_npc       = br_p ? addr_p : (r_pc + 32'd4);
  assign w_pred_addr = br_p ? addr_p : 32'd0;
  assign w_consumed  = r_if_valid && !stall_i;
  assign w_free      = !r_if_valid || w_consumed;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_load_fetch = 1'b0;
    w_load_buf   = 1'b0;
    w_fill_buf   = 1'b0;
    if (flush_i) begin
      w_pc_nxt = flush_addr;
      case (r_state)
        // An outstanding request must still be drained. A KILL that sees its
        // mem_done together with a new flush has nothing left to wait for.
        FETCH, KILL: w_state_nxt = mem_done ? FETCH : KILL;
        default:     w_state_nxt = FETCH;
      endcase
    end else begin
      case (r_state)
        IDLE: w_state_nxt = FETCH;
        FETCH: begin
          if (mem_done) begin
            w_pc_nxt = w_npc;
            if (w_free) begin
              w_load_fetch = 1'b1;
            end else begin
              w_fill_buf  = 1'b1;
              w_state_nxt = FULL;
            end
          end
        end
        KILL: begin
          if (mem_done) w_state_nxt = FETCH;
        end
        FULL: begin
          if (w_consumed) begin
            w_load_buf  = 1'b1;
            w_state_nxt = FETCH;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= 32'd0;
      r_if_inst   <= 32'd0;
      r_if_taken  <= 1'b0;
      r_if_paddr  <= 32'd0;
      r_buf_pc    <= 32'd0;
      r_buf_inst  <= 32'd0;
      r_buf_taken <= 1'b0;
      r_buf_paddr <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_mem_req <= (w_state_nxt == FETCH) || (w_state_nxt == KILL);
      // KILL keeps presenting the abandoned address until it completes.
      if (w_state_nxt == FETCH) r_mem_addr <= w_pc_nxt;

      if (flush_i) begin
        r_if_valid <= 1'b0;
      end else if (w_load_fetch) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_pc;
        r_if_inst  <= mem_data;
        r_if_taken <= br_p;
        r_if_paddr <= w_pred_addr;
      end else if (w_load_buf) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_buf_pc;
        r_if_inst  <= r_buf_inst;
        r_if_taken <= r_buf_taken;
        r_if_paddr <= r_buf_paddr;
      end else if (w_consumed) begin
        r_if_valid <= 1'b0;
      end

      if (w_fill_buf) begin
        r_buf_pc    <= r_pc;
        r_buf_inst  <= mem_data;
        r_buf_taken <= br_p;
        r_buf_paddr <= w_pred_addr;
      end
    end
  end

  assign pc_o          = r_pc;
  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign if_valid      = r_if_valid;
  assign if_pc         = r_if_pc;
  assign if_inst       = r_if_inst;
  assign if_pred_taken = r_if_taken;
  assign if_pred_addr  = r_if_paddr;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_o;
  logic        br_p;
  logic [31:0] addr_p;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_pred_taken;
  logic [31:0] if_pred_addr;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_o(pc_o), .br_p(br_p), .addr_p(addr_p),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done),
    .mem_data(mem_data), .stall_i(stall_i), .flush_i(flush_i),
    .flush_addr(flush_addr), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_pred_taken(if_pred_taken),
    .if_pred_addr(if_pred_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; br_p = 1'b0; addr_p = 32'd0; mem_done = 1'b0; mem_data = 32'd0;
    stall_i = 1'b0; flush_i = 1'b0; flush_addr = 32'd0;
    tick(); tick();
    check("rst_pc", pc_o, 32'h0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_ifpc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_taken", {31'd0, if_pred_taken}, 32'd0);
    check("rst_paddr", if_pred_addr, 32'h0);

    // IDLE -> FETCH
    rst = 1'b0;
    tick();
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
    check("first_valid", {31'd0, if_valid}, 32'd0);

    // one wait cycle, then data for PC 0
    tick();
    check("wait_valid", {31'd0, if_valid}, 32'd0);
    mem_done = 1'b1; mem_data = 32'h00000013;
    tick();
    check("seq_valid", {31'd0, if_valid}, 32'd1);
    check("seq_pc", if_pc, 32'h0);
    check("seq_inst", if_inst, 32'h00000013);
    check("seq_taken", {31'd0, if_pred_taken}, 32'd0);
    check("seq_next_addr", mem_addr, 32'h4);
    check("seq_req", {31'd0, mem_req}, 32'd1);

    // back-to-back: PC 4
    mem_data = 32'h00400093;
    tick();
    check("b2b_pc", if_pc, 32'h4);
    check("b2b_inst", if_inst, 32'h00400093);
    check("b2b_addr", mem_addr, 32'h8);

    // predicted taken at PC 8
    br_p = 1'b1; addr_p = 32'h100; mem_data = 32'h0F80006F;
    tick();
    check("bp_pc", if_pc, 32'h8);
    check("bp_taken", {31'd0, if_pred_taken}, 32'd1);
    check("bp_paddr", if_pred_addr, 32'h100);
    check("bp_next_addr", mem_addr, 32'h100);
    check("bp_pc_o", pc_o, 32'h100);
    br_p = 1'b0; addr_p = 32'd0;

    // idle cycle drains the output
    mem_done = 1'b0;
    tick();
    check("drain_valid", {31'd0, if_valid}, 32'd0);

    // stall while two fetches complete
    stall_i = 1'b1; mem_done = 1'b1; mem_data = 32'hA1;
    tick();
    check("st1_valid", {31'd0, if_valid}, 32'd1);
    check("st1_pc", if_pc, 32'h100);
    check("st1_taken_clear", {31'd0, if_pred_taken}, 32'd0);
    check("st1_paddr_clear", if_pred_addr, 32'h0);
    mem_data = 32'hA2;
    tick();
    check("st2_req", {31'd0, mem_req}, 32'd0);
    check("st2_pc_held", if_pc, 32'h100);
    check("st2_inst_held", if_inst, 32'hA1);
    check("st2_pc_o", pc_o, 32'h108);
    // FULL ignores a stray mem_done and keeps the output stable
    mem_data = 32'hEE;
    tick();
    check("st3_req", {31'd0, mem_req}, 32'd0);
    check("st3_inst_held", if_inst, 32'hA1);
    check("st3_pc_o", pc_o, 32'h108);
    // release
    stall_i = 1'b0; mem_done = 1'b0;
    tick();
    check("rel_valid", {31'd0, if_valid}, 32'd1);
    check("rel_pc", if_pc, 32'h104);
    check("rel_inst", if_inst, 32'hA2);
    check("rel_req", {31'd0, mem_req}, 32'd1);
    check("rel_addr", mem_addr, 32'h108);

    // flush coincident with mem_done: data dropped, redirect to 0x10
    flush_i = 1'b1; flush_addr = 32'h10; mem_done = 1'b1; mem_data = 32'hDEAD;
    tick();
    check("fd_valid", {31'd0, if_valid}, 32'd0);
    check("fd_addr", mem_addr, 32'h10);
    check("fd_req", {31'd0, mem_req}, 32'd1);

    // flush with request outstanding at PC 0x10
    flush_addr = 32'h200; mem_done = 1'b0;
    tick();
    check("fk_valid", {31'd0, if_valid}, 32'd0);
    check("fk_req", {31'd0, mem_req}, 32'd1);
    check("fk_addr_held", mem_addr, 32'h10);
    check("fk_pc_o", pc_o, 32'h200);
    flush_i = 1'b0;
    tick();
    check("kill_wait_addr", mem_addr, 32'h10);
    mem_done = 1'b1; mem_data = 32'hBAD;
    tick();
    check("kill_drop_valid", {31'd0, if_valid}, 32'd0);
    check("kill_new_addr", mem_addr, 32'h200);

    // wrap: flush to 0xFFFFFFFC coincident with mem_done
    flush_i = 1'b1; flush_addr = 32'hFFFFFFFC; mem_data = 32'hBAD2;
    tick();
    check("wr_valid", {31'd0, if_valid}, 32'd0);
    check("wr_addr", mem_addr, 32'hFFFFFFFC);
    flush_i = 1'b0; mem_data = 32'h77;
    tick();
    check("wr_ifpc", if_pc, 32'hFFFFFFFC);
    check("wr_inst", if_inst, 32'h77);
    check("wr_next_addr", mem_addr, 32'h0);
    check("wr_pc_o", pc_o, 32'h0);

    // reset mid-request; a late mem_done in IDLE is ignored
    mem_done = 1'b0; rst = 1'b1;
    tick();
    check("mr_req", {31'd0, mem_req}, 32'd0);
    check("mr_valid", {31'd0, if_valid}, 32'd0);
    rst = 1'b0; mem_done = 1'b1; mem_data = 32'h55;
    tick();
    check("late_done_valid", {31'd0, if_valid}, 32'd0);
    check("late_done_req", {31'd0, mem_req}, 32'd1);
    check("late_done_addr", mem_addr, 32'h0);
    mem_done = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
